// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter sharing one memory port, with an in-order
// read-tracking FIFO that steers each returning response to its requester.
module mem_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              m0_valid,
    output logic                              m0_ready,
    input  logic                              m0_write_en,
    input  logic [DATA_W/8-1:0]               m0_byte_en,
    input  logic [ADDR_W-1:0]                 m0_addr,
    input  logic [DATA_W-1:0]                 m0_wdata,
    output logic [DATA_W-1:0]                 m0_rdata,
    output logic                              m0_rvalid,

    input  logic                              m1_valid,
    output logic                              m1_ready,
    input  logic                              m1_write_en,
    input  logic [DATA_W/8-1:0]               m1_byte_en,
    input  logic [ADDR_W-1:0]                 m1_addr,
    input  logic [DATA_W-1:0]                 m1_wdata,
    output logic [DATA_W-1:0]                 m1_rdata,
    output logic                              m1_rvalid,

    output logic                              s_valid,
    input  logic                              s_ready,
    output logic                              s_write_en,
    output logic [DATA_W/8-1:0]               s_byte_en,
    output logic [ADDR_W-1:0]                 s_addr,
    output logic [DATA_W-1:0]                 s_wdata,
    input  logic [DATA_W-1:0]                 s_rdata,
    input  logic                              s_rvalid,

    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              resp_err
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic                       owner_q, owner_d;
    logic                       last_q, last_d;
    logic [MAX_OUTSTANDING-1:0] id_q;
    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       resp_err_q, resp_err_d;

    logic fifo_full;
    logic fifo_empty;
    logic elig0, elig1;
    logic grant, have_grant;
    logic sel_valid, sel_write_en;
    logic accept, push, pop, head;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // Reads need a free tracking slot; writes never consume one.
    assign elig0 = m0_valid && (m0_write_en || !fifo_full);
    assign elig1 = m1_valid && (m1_write_en || !fifo_full);

    always_comb begin
        grant      = 1'b0;
        have_grant = 1'b0;
        if (state_q == ST_LOCKED) begin
            grant      = owner_q;
            have_grant = 1'b1;
        end else if (elig0 && elig1) begin
            grant      = ~last_q;
            have_grant = 1'b1;
        end else if (elig0) begin
            grant      = 1'b0;
            have_grant = 1'b1;
        end else if (elig1) begin
            grant      = 1'b1;
            have_grant = 1'b1;
        end
    end

    always_comb begin
        sel_valid    = grant ? m1_valid    : m0_valid;
        sel_write_en = grant ? m1_write_en : m0_write_en;
        s_byte_en    = grant ? m1_byte_en  : m0_byte_en;
        s_addr       = grant ? m1_addr     : m0_addr;
        s_wdata      = grant ? m1_wdata    : m0_wdata;
    end

    // A locked read keeps its grant while the FIFO is full but is not presented.
    assign s_valid    = !rst && have_grant && sel_valid && (sel_write_en || !fifo_full);
    assign s_write_en = sel_write_en;
    assign accept     = s_valid && s_ready;
    assign m0_ready   = accept && !grant;
    assign m1_ready   = accept &&  grant;

    assign push = accept && !sel_write_en;
    assign pop  = s_rvalid && !fifo_empty;
    assign head = id_q[rptr_q];

    assign m0_rvalid   = !rst && pop && !head;
    assign m1_rvalid   = !rst && pop &&  head;
    assign m0_rdata    = s_rdata;
    assign m1_rdata    = s_rdata;
    assign outstanding = count_q;
    assign resp_err    = resp_err_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (accept) begin
            state_d = ST_IDLE;
            last_d  = grant;
        end else if (have_grant) begin
            state_d = ST_LOCKED;
            owner_d = grant;
        end
    end

    always_comb begin
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d    = count_q;
        resp_err_d = resp_err_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (s_rvalid && fifo_empty) begin
            resp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Slot contents are only meaningful between push and pop, so no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            id_q[wptr_q] <= grant;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven check of mem_arbiter arbitration, locking, FIFO
// limits, response routing, stray-response error and reset behaviour.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAXO   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_valid, m0_ready, m0_write_en, m0_rvalid;
    logic [3:0]        m0_byte_en;
    logic [31:0]       m0_addr, m0_wdata, m0_rdata;
    logic              m1_valid, m1_ready, m1_write_en, m1_rvalid;
    logic [3:0]        m1_byte_en;
    logic [31:0]       m1_addr, m1_wdata, m1_rdata;
    logic              s_valid, s_ready, s_write_en, s_rvalid;
    logic [3:0]        s_byte_en;
    logic [31:0]       s_addr, s_wdata, s_rdata;
    logic [2:0]        outstanding;
    logic              resp_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write_en(m0_write_en),
        .m0_byte_en(m0_byte_en), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write_en(m1_write_en),
        .m1_byte_en(m1_byte_en), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .s_valid(s_valid), .s_ready(s_ready), .s_write_en(s_write_en),
        .s_byte_en(s_byte_en), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .outstanding(outstanding), .resp_err(resp_err)
    );

    typedef struct {
        logic       rst;
        logic       v0, we0;
        logic [7:0] a0;
        logic       v1, we1;
        logic [7:0] a1;
        logic       srdy, srv;
        logic [7:0] srd;
        logic       e_r0, e_r1, e_sv, e_swe;
        logic [7:0] e_addr;
        logic       e_rv0, e_rv1;
        logic [2:0] e_outs;
        logic       e_err;
    } vec_t;

    function automatic vec_t V(
        input logic rst_, v0, we0, input logic [7:0] a0,
        input logic v1, we1, input logic [7:0] a1,
        input logic srdy, srv, input logic [7:0] srd,
        input logic r0, r1, sv, swe, input logic [7:0] addr,
        input logic rv0, rv1, input logic [2:0] outs, input logic err);
        vec_t v;
        v.rst = rst_; v.v0 = v0; v.we0 = we0; v.a0 = a0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1;
        v.srdy = srdy; v.srv = srv; v.srd = srd;
        v.e_r0 = r0; v.e_r1 = r1; v.e_sv = sv; v.e_swe = swe; v.e_addr = addr;
        v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_outs = outs; v.e_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        rst         = v.rst;
        m0_valid    = v.v0;  m0_write_en = v.we0; m0_addr = {24'h0, v.a0};
        m1_valid    = v.v1;  m1_write_en = v.we1; m1_addr = {24'h0, v.a1};
        s_ready     = v.srdy;
        s_rvalid    = v.srv;
        s_rdata     = {24'h0, v.srd};
        #1;
        chk("handshake", idx, {61'h0, m0_ready, m1_ready, s_valid},
            {61'h0, v.e_r0, v.e_r1, v.e_sv});
        chk("rvalid", idx, {62'h0, m0_rvalid, m1_rvalid}, {62'h0, v.e_rv0, v.e_rv1});
        chk("outstanding", idx, {61'h0, outstanding}, {61'h0, v.e_outs});
        chk("resp_err", idx, {63'h0, resp_err}, {63'h0, v.e_err});
        if (v.e_sv) begin
            chk("payload", idx, {31'h0, s_write_en, s_addr}, {31'h0, v.e_swe, 24'h0, v.e_addr});
            chk("wdata_be", idx, {28'h0, s_byte_en, s_wdata},
                (v.e_addr == (v.e_r1 || (!v.e_r0 && v.e_addr == v.a1 && v.v1 && v.e_addr != v.a0))
                  ? 64'h0 : 64'h0) | (s_addr == m1_addr && m1_valid && !(s_addr == m0_addr && m0_valid)
                  ? {28'h0, 4'h3, 32'hBBBB_0001} : {28'h0, 4'hF, 32'hAAAA_0000}));
        end
        if (v.srv && !v.rst) begin
            chk("rdata", idx, {m0_rdata, m1_rdata}, {24'h0, v.srd, 24'h0, v.srd});
        end
    endtask

    vec_t tbl[23];
    vec_t hs[12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_valid = 1'b0; m0_write_en = 1'b0; m0_addr = '0;
        m1_valid = 1'b0; m1_write_en = 1'b0; m1_addr = '0;
        m0_byte_en = 4'hF; m0_wdata = 32'hAAAA_0000;
        m1_byte_en = 4'h3; m1_wdata = 32'hBBBB_0001;
        s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;

        // Simultaneous reads, then responses routed in order
        tbl[0]  = V(0,1,0,8'h10,1,0,8'h20,1,0,8'h00, 1,0,1,0,8'h10,0,0,3'd0,0);
        tbl[1]  = V(0,0,0,8'h00,1,0,8'h20,1,0,8'h00, 0,1,1,0,8'h20,0,0,3'd1,0);
        tbl[2]  = V(0,0,0,8'h00,0,0,8'h00,1,1,8'h0A, 0,0,0,0,8'h00,1,0,3'd2,0);
        tbl[3]  = V(0,0,0,8'h00,0,0,8'h00,1,1,8'h0B, 0,0,0,0,8'h00,0,1,3'd1,0);
        // Grant locks on m1 while s_ready is low
        tbl[4]  = V(0,0,0,8'h00,1,0,8'h21,0,0,8'h00, 0,0,1,0,8'h21,0,0,3'd0,0);
        tbl[5]  = V(0,1,0,8'h11,1,0,8'h21,0,0,8'h00, 0,0,1,0,8'h21,0,0,3'd0,0);
        tbl[6]  = V(0,1,0,8'h11,1,0,8'h21,0,0,8'h00, 0,0,1,0,8'h21,0,0,3'd0,0);
        tbl[7]  = V(0,1,0,8'h11,1,0,8'h21,1,0,8'h00, 0,1,1,0,8'h21,0,0,3'd0,0);
        tbl[8]  = V(0,1,0,8'h11,0,0,8'h00,1,0,8'h00, 1,0,1,0,8'h11,0,0,3'd1,0);
        tbl[9]  = V(0,0,0,8'h00,0,0,8'h00,1,1,8'h0C, 0,0,0,0,8'h00,0,1,3'd2,0);
        tbl[10] = V(0,0,0,8'h00,0,0,8'h00,1,1,8'h0D, 0,0,0,0,8'h00,1,0,3'd1,0);
        // Fill the FIFO; a read blocks while a write passes
        tbl[11] = V(0,1,0,8'h30,0,0,8'h00,1,0,8'h00, 1,0,1,0,8'h30,0,0,3'd0,0);
        tbl[12] = V(0,1,0,8'h31,0,0,8'h00,1,0,8'h00, 1,0,1,0,8'h31,0,0,3'd1,0);
        tbl[13] = V(0,1,0,8'h32,0,0,8'h00,1,0,8'h00, 1,0,1,0,8'h32,0,0,3'd2,0);
        tbl[14] = V(0,1,0,8'h33,0,0,8'h00,1,0,8'h00, 1,0,1,0,8'h33,0,0,3'd3,0);
        tbl[15] = V(0,1,0,8'h34,1,1,8'h40,1,0,8'h00, 0,1,1,1,8'h40,0,0,3'd4,0);
        tbl[16] = V(0,1,0,8'h34,0,0,8'h00,1,1,8'h0E, 0,0,0,0,8'h00,1,0,3'd4,0);
        tbl[17] = V(0,1,0,8'h34,0,0,8'h00,1,0,8'h00, 1,0,1,0,8'h34,0,0,3'd3,0);
        // No pop-to-push bypass when full; push+pop together; pointer wrap
        tbl[18] = V(0,0,0,8'h00,1,0,8'h22,1,1,8'h0F, 0,0,0,0,8'h00,1,0,3'd4,0);
        tbl[19] = V(0,0,0,8'h00,1,0,8'h22,1,1,8'h10, 0,1,1,0,8'h22,1,0,3'd3,0);
        tbl[20] = V(0,0,0,8'h00,0,0,8'h00,1,1,8'h11, 0,0,0,0,8'h00,1,0,3'd3,0);
        tbl[21] = V(0,0,0,8'h00,0,0,8'h00,1,1,8'h12, 0,0,0,0,8'h00,1,0,3'd2,0);
        tbl[22] = V(0,0,0,8'h00,0,0,8'h00,1,1,8'h13, 0,0,0,0,8'h00,0,1,3'd1,0);

        repeat (2) @(posedge clk);
        // Reset holds every handshake/response output low
        step(V(1,1,0,8'h10,1,0,8'h20,1,1,8'h55, 0,0,0,0,8'h00,0,0,3'd0,0), 100);

        for (int i = 0; i < 23; i++) step(tbl[i], i);

        // Stray response: sticky error until reset
        step(V(0,0,0,8'h00,0,0,8'h00,1,1,8'h14, 0,0,0,0,8'h00,0,0,3'd0,0), 200);
        step(V(0,0,0,8'h00,0,0,8'h00,1,0,8'h00, 0,0,0,0,8'h00,0,0,3'd0,1), 201);
        step(V(0,1,0,8'h50,0,0,8'h00,1,0,8'h00, 1,0,1,0,8'h50,0,0,3'd0,1), 202);
        step(V(0,0,0,8'h00,0,0,8'h00,1,1,8'h15, 0,0,0,0,8'h00,1,0,3'd1,1), 203);
        step(V(1,1,0,8'h50,1,0,8'h60,1,0,8'h00, 0,0,0,0,8'h00,0,0,3'd0,1), 204);

        // Reset with reads in flight and a lock held
        step(V(0,1,0,8'h51,1,0,8'h60,1,0,8'h00, 1,0,1,0,8'h51,0,0,3'd0,0), 300);
        step(V(0,0,0,8'h00,1,0,8'h60,1,0,8'h00, 0,1,1,0,8'h60,0,0,3'd1,0), 301);
        step(V(0,1,0,8'h52,0,0,8'h00,0,0,8'h00, 0,0,1,0,8'h52,0,0,3'd2,0), 302);
        step(V(1,1,0,8'h52,0,0,8'h00,0,0,8'h00, 0,0,0,0,8'h00,0,0,3'd2,0), 303);
        step(V(0,0,0,8'h00,1,1,8'h61,1,0,8'h00, 0,1,1,1,8'h61,0,0,3'd0,0), 304);
        step(V(0,0,0,8'h00,0,0,8'h00,1,1,8'h16, 0,0,0,0,8'h00,0,0,3'd0,0), 305);
        step(V(0,0,0,8'h00,0,0,8'h00,1,0,8'h00, 0,0,0,0,8'h00,0,0,3'd0,1), 306);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
